// File: rtl/vx_stream_wrr_arb.sv
// Weighted round-robin packet arbiter: merges NUM_INPUTS valid/ready streams onto one output, never interleaving packets.
// Latency: exactly 1 cycle from an accepted input beat to the registered output.
// Backpressure: only the selected input sees ready_in, and only while the output register can accept (empty or draining).
module vx_stream_wrr_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 32,
    parameter int WEIGHTW    = 4,
    localparam int SELW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS-1:0]                valid_in,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]     data_in,
    input  logic [NUM_INPUTS-1:0]                last_in,
    output logic [NUM_INPUTS-1:0]                ready_in,
    input  logic [NUM_INPUTS-1:0][WEIGHTW-1:0]   weights,
    output logic                                 valid_out,
    output logic [DATAW-1:0]                     data_out,
    output logic                                 last_out,
    output logic [SELW-1:0]                      sel_out,
    input  logic                                 ready_out
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_n;
    logic [SELW-1:0]    g, g_n;
    logic [SELW-1:0]    ptr, ptr_n;
    logic [WEIGHTW-1:0] cred, cred_n;
    logic               at_bound, at_bound_n;   // last accepted beat of g closed a packet

    logic [SELW-1:0]    idle_sel;
    logic [SELW-1:0]    sel;
    logic               any_valid;
    logic               can_accept;
    logic               sel_valid;
    logic               sel_last;
    logic               fire;
    logic [WEIGHTW-1:0] load_cred;

    // Index following i, wrapping at NUM_INPUTS
    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
        int n;
        n = int'(i) + 1;
        if (n >= NUM_INPUTS) n = 0;
        return n[SELW-1:0];
    endfunction

    // Rotating-priority search for the IDLE candidate, starting at ptr
    always_comb begin
        idle_sel  = ptr;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            int              idx;
            logic [SELW-1:0] idx_s;
            idx   = (int'(ptr) + k) % NUM_INPUTS;
            idx_s = idx[SELW-1:0];
            if (!any_valid && valid_in[idx_s]) begin
                any_valid = 1'b1;
                idle_sel  = idx_s;
            end
        end
    end

    // Selected input, its handshake signals and its credit load value
    always_comb begin
        sel        = (state == LOCKED) ? g : idle_sel;
        can_accept = !valid_out || ready_out;
        sel_valid  = valid_in[sel];
        sel_last   = last_in[sel];
        load_cred  = (weights[sel] == '0) ? WEIGHTW'(1) : weights[sel];
    end

    // FSM outputs: one-hot ready to the selected input and the resulting transfer
    always_comb begin
        ready_in = '0;
        if (!reset && can_accept && (state == LOCKED || any_valid)) begin
            ready_in[sel] = 1'b1;
        end
        fire = ready_in[sel] && sel_valid;
    end

    // FSM next state: grant on first beat, spend credit on packet ends, release on exhaustion or idle boundary
    always_comb begin
        state_n    = state;
        g_n        = g;
        ptr_n      = ptr;
        cred_n     = cred;
        at_bound_n = at_bound;
        case (state)
            IDLE: begin
                if (fire) begin
                    g_n        = sel;
                    at_bound_n = sel_last;
                    if (sel_last) begin
                        cred_n = load_cred - WEIGHTW'(1);
                        if (load_cred == WEIGHTW'(1)) begin
                            ptr_n = next_idx(sel);
                        end else begin
                            state_n = LOCKED;
                        end
                    end else begin
                        cred_n  = load_cred;
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (fire) begin
                    at_bound_n = sel_last;
                    if (sel_last) begin
                        cred_n = cred - WEIGHTW'(1);
                        if (cred == WEIGHTW'(1)) begin
                            state_n = IDLE;
                            ptr_n   = next_idx(g);
                        end
                    end
                end else if (at_bound && !sel_valid) begin
                    // Granted input has nothing more to send: give up the rest of its credit
                    state_n = IDLE;
                    ptr_n   = next_idx(g);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= '0;
            cred     <= '0;
            at_bound <= 1'b0;
        end else begin
            state    <= state_n;
            g        <= g_n;
            ptr      <= ptr_n;
            cred     <= cred_n;
            at_bound <= at_bound_n;
        end
    end

    // Output register: fills on a transfer, empties when drained without refill, holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
            sel_out   <= '0;
        end else if (can_accept) begin
            valid_out <= fire;
            if (fire) begin
                data_out <= data_in[sel];
                last_out <= sel_last;
                sel_out  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_vx_stream_wrr_arb.sv
// Self-checking bench for vx_stream_wrr_arb: packet sources per input, scoreboard of expected output beats.
// Latency: expected beats are queued before stimulus and popped on every output transfer.
// Backpressure: ready_out is driven per scenario; stall hold and ready gating are checked directly.
module tb_vx_stream_wrr_arb;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int SW = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NI-1:0]         valid_in;
    logic [NI-1:0][DW-1:0] data_in;
    logic [NI-1:0]         last_in;
    logic [NI-1:0]         ready_in;
    logic [NI-1:0][WW-1:0] weights;
    logic                  valid_out;
    logic [DW-1:0]         data_out;
    logic                  last_out;
    logic [SW-1:0]         sel_out;
    logic                  ready_out;

    always #5 clk = ~clk;

    vx_stream_wrr_arb #(.NUM_INPUTS(NI), .DATAW(DW), .WEIGHTW(WW)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .weights   (weights),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    // Source state per input
    int            pkts_left [NI];
    int            plen      [NI];
    int            beat      [NI];
    logic [7:0]    pkt       [NI];
    logic [NI-1:0] hold;

    logic [63:0]   exp_q[$];
    int            n_checks;
    int            n_fail;
    int            out_cnt;
    int            extra_cnt;
    int            proto_err;

    // Samples taken at the falling edge of the most recent step
    logic          s_vo;
    logic [NI-1:0] s_rdy;
    logic [63:0]   s_hold;
    logic [63:0]   snap;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int i, input logic [7:0] p, input int b, input logic l);
        logic [SW-1:0] s;
        s = i[SW-1:0];
        return {29'b0, s, l, 8'(i), p, 16'(b)};
    endfunction

    task automatic push_pkt(input int i, input int k);
        for (int b = 0; b < plen[i]; b++) begin
            exp_q.push_back(mk(i, pkt[i] + 8'(k), b, b == plen[i] - 1));
        end
    endtask

    function automatic logic src_busy();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NI; i++) if (pkts_left[i] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            valid_in[i] = (pkts_left[i] > 0) && !hold[i];
            data_in[i]  = {8'(i), pkt[i], 16'(beat[i])};
            last_in[i]  = (beat[i] == plen[i] - 1);
        end
    endtask

    // One clock: drive, sample/score mid-cycle, advance sources after the edge
    task automatic step();
        logic [NI-1:0] fire_v;
        drive();
        @(negedge clk);
        fire_v = valid_in & ready_in;
        s_vo   = valid_out;
        s_rdy  = ready_in;
        s_hold = {29'b0, sel_out, last_out, data_out};
        if ($countones(ready_in) > 1) proto_err++;
        if (valid_out && !ready_out && ready_in != '0) proto_err++;
        if (valid_out && ready_out) begin
            out_cnt++;
            if (exp_q.size() == 0) extra_cnt++;
            else check("beat", s_hold, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (fire_v[i]) begin
                beat[i]++;
                if (beat[i] >= plen[i]) begin
                    beat[i] = 0;
                    pkt[i]++;
                    pkts_left[i]--;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NI; i++) pkts_left[i] = 0;
        hold = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < 500) begin
            step();
            n++;
        end
        step();
        step();
        check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_src"}, 64'(src_busy()), 64'(0));
        check({tag, "_extra"}, 64'(extra_cnt), 64'(0));
        check({tag, "_proto"}, 64'(proto_err), 64'(0));
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        weights[0] = WW'(w0);
        weights[1] = WW'(w1);
        weights[2] = WW'(w2);
        weights[3] = WW'(w3);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; out_cnt = 0; extra_cnt = 0; proto_err = 0;
        reset = 1'b1; ready_out = 1'b1; hold = '0;
        valid_in = '0; data_in = '0; last_in = '0;
        set_weights(1, 1, 1, 1);
        for (int i = 0; i < NI; i++) begin
            pkts_left[i] = 0; plen[i] = 1; beat[i] = 0; pkt[i] = 8'(16 * i);
        end

        // Reset state
        do_reset();
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_last_out", 64'(last_out), 64'(0));
        check("rst_sel_out", 64'(sel_out), 64'(0));
        check("rst_ready_in", 64'(ready_in), 64'(0));

        // Scenario 1: equal weights, single-beat packets, full throughput rotation
        do_reset();
        set_weights(1, 1, 1, 1);
        for (int i = 0; i < NI; i++) begin plen[i] = 1; pkts_left[i] = 3; end
        for (int r = 0; r < 3; r++) for (int i = 0; i < NI; i++) push_pkt(i, r);
        step();
        check("s1_first_vo", 64'(s_vo), 64'(0));
        out_cnt = 0;
        repeat (12) step();
        check("s1_throughput", 64'(out_cnt), 64'(12));
        drain("s1");

        // Scenario 2: input 3 weight 3, two-beat packets; weight change mid-lock ignored
        do_reset();
        set_weights(1, 1, 1, 3);
        for (int i = 0; i < NI; i++) begin plen[i] = 2; pkts_left[i] = (i == 3) ? 6 : 2; end
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, r); push_pkt(1, r); push_pkt(2, r);
            for (int q = 0; q < 3; q++) push_pkt(3, r * 3 + q);
        end
        repeat (8) step();
        weights[3] = WW'(1);
        repeat (3) step();
        weights[3] = WW'(3);
        drain("s2");

        // Scenario 3: mid-packet valid drop on input 1 produces bubbles, no lock release
        do_reset();
        set_weights(1, 1, 1, 1);
        plen[1] = 4; pkts_left[1] = 1;
        plen[2] = 1; pkts_left[2] = 2;
        push_pkt(1, 0); push_pkt(2, 0); push_pkt(2, 1);
        step(); step();
        hold[1] = 1'b1;
        step();
        step();
        check("s3_bubble1", 64'(s_vo), 64'(0));
        check("s3_no_rdy2", 64'(s_rdy[2]), 64'(0));
        hold[1] = 1'b0;
        step();
        check("s3_bubble2", 64'(s_vo), 64'(0));
        drain("s3");

        // Scenario 4: five-cycle output stall holds the register and blocks all inputs
        do_reset();
        set_weights(1, 1, 1, 1);
        plen[0] = 1; pkts_left[0] = 4;
        plen[2] = 1; pkts_left[2] = 4;
        for (int k = 0; k < 4; k++) begin push_pkt(0, k); push_pkt(2, k); end
        repeat (3) step();
        ready_out = 1'b0;
        step();
        check("s4_stall_vo", 64'(s_vo), 64'(1));
        check("s4_stall_rdy", 64'(s_rdy), 64'(0));
        snap = s_hold;
        repeat (4) begin
            step();
            check("s4_hold", s_hold, snap);
            check("s4_stall_rdy", 64'(s_rdy), 64'(0));
        end
        ready_out = 1'b1;
        drain("s4");

        // Scenario 5: input 0 with spare credit goes idle at a boundary; lock released, input 2 next
        do_reset();
        set_weights(4, 1, 1, 1);
        plen[0] = 2; pkts_left[0] = 1;
        plen[2] = 1; pkts_left[2] = 1;
        push_pkt(0, 0); push_pkt(2, 0);
        step(); step();
        step();
        check("s5_rel_vo", 64'(s_vo), 64'(1));
        check("s5_rel_rdy2", 64'(s_rdy[2]), 64'(0));
        step();
        check("s5_bubble", 64'(s_vo), 64'(0));
        check("s5_grant2", 64'(s_rdy), 64'(4'b0100));
        drain("s5");

        // Scenario 6: reset mid-packet of input 3 abandons it; input 0 wins afterwards
        do_reset();
        set_weights(1, 1, 1, 1);
        plen[3] = 4; pkts_left[3] = 1;
        exp_q.push_back(mk(3, pkt[3], 0, 1'b0));
        exp_q.push_back(mk(3, pkt[3], 1, 1'b0));
        step(); step();
        reset = 1'b1;
        beat[3] = 0; pkt[3]++; plen[3] = 1; pkts_left[3] = 1;
        plen[0] = 1; pkts_left[0] = 1;
        push_pkt(0, 0); push_pkt(3, 0);
        step();
        check("s6_rst_rdy", 64'(s_rdy), 64'(0));
        reset = 1'b0;
        step();
        check("s6_post_vo", 64'(s_vo), 64'(0));
        check("s6_grant0", 64'(s_rdy), 64'(4'b0001));
        drain("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
